// File: rtl/mem_io_pkg.sv
// Shared types and constants for the memory / memory-mapped I/O stage.
package mem_io_pkg;

    // Request sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAM_RD = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // RISC-V funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Register offsets inside the I/O window
    localparam logic [31:0] SW_OFS   = 32'd0;
    localparam logic [31:0] BTN_OFS  = 32'd4;
    localparam logic [31:0] DISP_OFS = 32'd8;
    localparam logic [31:0] IO_SPAN  = 32'd12;

    // Bit positions in the sticky error vector
    localparam int ERR_MISALIGN   = 0;
    localparam int ERR_UNMAPPED   = 1;
    localparam int ERR_IO_SUBWORD = 2;
    localparam int ERR_FUNCT3     = 3;

    // Pick the addressed byte/half out of a RAM word and extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LBU:  r = {24'b0, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LHU:  r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern (bit0 = segment a).
module seven_seg_decoder (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Combinational glyph lookup; patterns are gfedcba, 0 = lit
    always_comb begin
        seg_o = 7'b1111111;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/mem_io_unit.sv
// Memory / memory-mapped I/O stage: one load or store at a time, served
// from a synchronous word RAM or from switch, button and display registers.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; all request fields are sampled on that edge.
// req_ready stays low from acceptance until after the single-cycle
// resp_valid pulse, so the requester may change its fields freely once
// the transfer edge has passed.
module mem_io_unit
    import mem_io_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic [15:0] switch_array,
    input  logic        button0,
    input  logic        button1,
    input  logic        button2,
    input  logic        button3,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic [6:0]  seg4,
    output logic [6:0]  seg5,
    output logic [6:0]  seg6,
    output logic [6:0]  seg7,
    output logic [7:0]  mem_error_vector,
    output logic [1:0]  dbg_state
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    state_e      state_q, state_d;
    logic        rdy_q;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] ram_rd_q;
    logic [31:0] mem_q [RAM_WORDS];
    logic [3:0]  sync1_q, sync2_q;
    logic [3:0]  flags_q, flags_d;
    logic [31:0] disp_q, disp_d;
    logic [3:0]  err_q, err_d;

    logic        accept;
    logic        is_half, is_word, f3_illegal, misalign;
    logic        ram_hit, io_hit, unmapped, io_sub;
    logic [31:0] io_ofs;
    logic [1:0]  io_sel;
    logic [3:0]  fault_bits;
    logic        fault;
    logic [AW-1:0] widx;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        ram_we, ram_re;
    logic        btn_rd, disp_wr;
    logic [3:0]  btn_raw, btn_rise;
    logic [31:0] io_rdata;
    logic [6:0]  seg_w [8];

    assign req_ready        = rdy_q && (state_q == ST_IDLE);
    assign accept           = req_valid && req_ready;
    assign resp_valid       = (state_q == ST_RESP);
    assign resp_rdata       = resp_rdata_q;
    assign resp_err         = resp_err_q;
    assign mem_error_vector = {4'b0000, err_q};
    assign dbg_state        = state_q;

    // Address and access-size decode of the incoming request
    assign is_half    = (req_funct3[1:0] == 2'b01);
    assign is_word    = (req_funct3[1:0] == 2'b10);
    assign f3_illegal = req_we ? (req_funct3 >= 3'b011)
                               : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    assign misalign   = !f3_illegal && ((is_half && req_addr[0]) ||
                                        (is_word && (req_addr[1:0] != 2'b00)));
    assign ram_hit    = (req_addr[31:AW+2] == '0);
    assign io_ofs     = req_addr - IO_BASE;
    assign io_hit     = (req_addr >= IO_BASE) && (io_ofs < IO_SPAN);
    assign io_sel     = io_ofs[3:2];
    assign unmapped   = !ram_hit && !io_hit;
    assign io_sub     = io_hit && (req_funct3 != F3_LW);

    always_comb begin
        fault_bits                 = 4'b0000;
        fault_bits[ERR_MISALIGN]   = misalign;
        fault_bits[ERR_UNMAPPED]   = unmapped;
        fault_bits[ERR_IO_SUBWORD] = io_sub;
        fault_bits[ERR_FUNCT3]     = f3_illegal;
    end
    assign fault = |fault_bits;

    assign widx    = req_addr[AW+1:2];
    assign ram_we  = accept && req_we && !fault && ram_hit;
    assign ram_re  = accept && !req_we && !fault && ram_hit;
    assign btn_rd  = accept && !req_we && !fault && io_hit && (io_sel == BTN_OFS[3:2]);
    assign disp_wr = accept && req_we && !fault && io_hit && (io_sel == DISP_OFS[3:2]);

    // Store lane enables and replicated store data
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
        endcase
    end

    // Word RAM: byte-enabled write and registered read on the acceptance edge
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[widx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (ram_re) ram_rd_q <= mem_q[widx];
    end

    // I/O register read mux
    assign btn_raw = {button3, button2, button1, button0};
    always_comb begin
        io_rdata = 32'd0;
        case (io_sel)
            SW_OFS[3:2]:   io_rdata = {16'b0, switch_array};
            BTN_OFS[3:2]:  io_rdata = {24'b0, flags_q, sync2_q};
            DISP_OFS[3:2]: io_rdata = disp_q;
            default:       io_rdata = 32'd0;
        endcase
    end

    // Button edge flags (a set in the same cycle as a clearing read wins),
    // display register and sticky error bits
    assign btn_rise = sync1_q & ~sync2_q;
    always_comb begin
        flags_d = (btn_rd ? 4'b0000 : flags_q) | btn_rise;
        disp_d  = disp_wr ? req_wdata : disp_q;
        err_d   = err_q | (accept ? fault_bits : 4'b0000);
    end

    // I/O state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            flags_q <= 4'b0000;
            disp_q  <= 32'd0;
            err_q   <= 4'b0000;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            flags_q <= flags_d;
            disp_q  <= disp_d;
            err_q   <= err_d;
        end
    end

    // Next-state and response data selection
    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (fault) begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (ram_hit && !req_we) begin
                        state_d = ST_RAM_RD;
                    end else begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = req_we ? 32'd0 : io_rdata;
                    end
                end
            end
            ST_RAM_RD: begin
                state_d      = ST_RESP;
                resp_err_d   = 1'b0;
                resp_rdata_d = extend_load(ram_rd_q, funct3_q, addr_lo_q);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, ready gating, captured request fields and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rdy_q        <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            rdy_q        <= 1'b1;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                funct3_q  <= req_funct3;
                addr_lo_q <= req_addr[1:0];
            end
        end
    end

    // One hex decoder per display digit, nibble k drives digit k
    for (genvar k = 0; k < 8; k++) begin : g_digit
        seven_seg_decoder u_dec (
            .hex_i (disp_q[4*k +: 4]),
            .seg_o (seg_w[k])
        );
    end

    assign seg0 = seg_w[0];
    assign seg1 = seg_w[1];
    assign seg2 = seg_w[2];
    assign seg3 = seg_w[3];
    assign seg4 = seg_w[4];
    assign seg5 = seg_w[5];
    assign seg6 = seg_w[6];
    assign seg7 = seg_w[7];

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed self-checking bench for mem_io_unit.
module tb_mem_io_unit;

    localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] switch_array;
    logic        button0, button1, button2, button3;
    logic [6:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [7:0]  mem_error_vector;
    logic [1:0]  dbg_state;

    int checks;
    int failures;

    mem_io_unit #(.RAM_WORDS(1024), .IO_BASE(IO_BASE)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .switch_array     (switch_array),
        .button0          (button0),
        .button1          (button1),
        .button2          (button2),
        .button3          (button3),
        .seg0             (seg0),
        .seg1             (seg1),
        .seg2             (seg2),
        .seg3             (seg3),
        .seg4             (seg4),
        .seg5             (seg5),
        .seg6             (seg6),
        .seg7             (seg7),
        .mem_error_vector (mem_error_vector),
        .dbg_state        (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and check latency, data, error flag and ready gating.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        int lat;
        logic got;
        logic leak;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat  = 0;
        got  = 1'b0;
        leak = 1'b0;
        rd   = 32'd0;
        er   = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (req_ready) leak = 1'b1;
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rd, exp_rdata);
        chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        chk({tag, "_busy"}, {31'b0, leak}, 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        switch_array = 16'h0000;
        button0      = 1'b0;
        button1      = 1'b0;
        button2      = 1'b0;
        button3      = 1'b0;

        // Reset values while reset is held
        #3 rst = 1'b0;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_vec", {24'b0, mem_error_vector}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        chk("rst_seg0", {25'b0, seg0}, 32'h40);
        chk("rst_seg7", {25'b0, seg7}, 32'h40);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_held", {31'b0, req_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rel", {31'b0, req_ready}, 32'd1);

        // RAM word store/load and latencies
        txn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'd0, 1'b0);
        txn("lw_10", 1'b0, 3'b010, 32'h10, 32'd0, 2, 32'hDEADBEEF, 1'b0);

        // Sub-word loads and byte store
        txn("lb_13", 1'b0, 3'b000, 32'h13, 32'd0, 2, 32'hFFFFFFDE, 1'b0);
        txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'd0, 2, 32'h000000DE, 1'b0);
        txn("lh_12", 1'b0, 3'b001, 32'h12, 32'd0, 2, 32'hFFFFDEAD, 1'b0);
        txn("lhu_10", 1'b0, 3'b101, 32'h10, 32'd0, 2, 32'h0000BEEF, 1'b0);
        txn("lb_10", 1'b0, 3'b000, 32'h10, 32'd0, 2, 32'hFFFFFFEF, 1'b0);
        txn("sb_11", 1'b1, 3'b000, 32'h11, 32'h00000055, 1, 32'd0, 1'b0);
        txn("lw_10_sb", 1'b0, 3'b010, 32'h10, 32'd0, 2, 32'hDEAD55EF, 1'b0);

        // Half store into the upper lanes
        txn("sw_14", 1'b1, 3'b010, 32'h14, 32'h11223344, 1, 32'd0, 1'b0);
        txn("sh_16", 1'b1, 3'b001, 32'h16, 32'h0000ABCD, 1, 32'd0, 1'b0);
        txn("lw_14", 1'b0, 3'b010, 32'h14, 32'd0, 2, 32'hABCD3344, 1'b0);
        txn("lhu_16", 1'b0, 3'b101, 32'h16, 32'd0, 2, 32'h0000ABCD, 1'b0);

        // Last RAM word
        txn("sw_ffc", 1'b1, 3'b010, 32'hFFC, 32'h0BADF00D, 1, 32'd0, 1'b0);
        txn("lw_ffc", 1'b0, 3'b010, 32'hFFC, 32'd0, 2, 32'h0BADF00D, 1'b0);

        // Switches and display
        switch_array = 16'hA5C3;
        txn("lw_sw", 1'b0, 3'b010, IO_BASE, 32'd0, 1, 32'h0000A5C3, 1'b0);
        txn("sw_swreg", 1'b1, 3'b010, IO_BASE, 32'hFFFFFFFF, 1, 32'd0, 1'b0);
        txn("lw_sw2", 1'b0, 3'b010, IO_BASE, 32'd0, 1, 32'h0000A5C3, 1'b0);
        txn("sw_disp", 1'b1, 3'b010, IO_BASE + 32'd8, 32'h01234567, 1, 32'd0, 1'b0);
        chk("seg0_7", {25'b0, seg0}, 32'h78);
        chk("seg1_6", {25'b0, seg1}, 32'h02);
        chk("seg4_3", {25'b0, seg4}, 32'h30);
        chk("seg7_0", {25'b0, seg7}, 32'h40);
        txn("lw_disp", 1'b0, 3'b010, IO_BASE + 32'd8, 32'd0, 1, 32'h01234567, 1'b0);

        // Button edge flags
        @(negedge clk);
        button2 = 1'b1;
        idle_cycles(5);
        button2 = 1'b0;
        idle_cycles(3);
        txn("btn_rd1", 1'b0, 3'b010, IO_BASE + 32'd4, 32'd0, 1, 32'h00000040, 1'b0);
        txn("btn_rd2", 1'b0, 3'b010, IO_BASE + 32'd4, 32'd0, 1, 32'h00000000, 1'b0);
        button0 = 1'b1;
        idle_cycles(4);
        txn("btn_hold1", 1'b0, 3'b010, IO_BASE + 32'd4, 32'd0, 1, 32'h00000011, 1'b0);
        txn("btn_hold2", 1'b0, 3'b010, IO_BASE + 32'd4, 32'd0, 1, 32'h00000001, 1'b0);
        button0 = 1'b0;
        idle_cycles(3);

        // Faults and sticky error bits
        chk("vec_clean", {24'b0, mem_error_vector}, 32'd0);
        txn("f_misal", 1'b0, 3'b010, 32'h12, 32'd0, 1, 32'd0, 1'b1);
        chk("vec_01", {24'b0, mem_error_vector}, 32'h01);
        txn("lw_10_f1", 1'b0, 3'b010, 32'h10, 32'd0, 2, 32'hDEAD55EF, 1'b0);
        txn("f_unmap", 1'b0, 3'b010, 32'h80000000, 32'd0, 1, 32'd0, 1'b1);
        chk("vec_03", {24'b0, mem_error_vector}, 32'h03);
        txn("f_iosub", 1'b0, 3'b000, IO_BASE, 32'd0, 1, 32'd0, 1'b1);
        chk("vec_07", {24'b0, mem_error_vector}, 32'h07);
        txn("f_f3ld", 1'b0, 3'b011, 32'h10, 32'd0, 1, 32'd0, 1'b1);
        chk("vec_0f", {24'b0, mem_error_vector}, 32'h0F);
        txn("f_st_misal", 1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 1, 32'd0, 1'b1);
        txn("f_st_f3", 1'b1, 3'b011, 32'h10, 32'h00000000, 1, 32'd0, 1'b1);
        txn("lw_10_f2", 1'b0, 3'b010, 32'h10, 32'd0, 2, 32'hDEAD55EF, 1'b0);
        txn("f_sb_disp", 1'b1, 3'b000, IO_BASE + 32'd8, 32'h000000FF, 1, 32'd0, 1'b1);
        chk("seg0_kept", {25'b0, seg0}, 32'h78);
        txn("f_ram_end", 1'b0, 3'b010, 32'h1000, 32'd0, 1, 32'd0, 1'b1);
        chk("vec_final", {24'b0, mem_error_vector}, 32'h0F);

        // Reset while a RAM load is in flight
        @(negedge clk);
        chk("mid_ready", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid_state_rd", {30'b0, dbg_state}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_state", {30'b0, dbg_state}, 32'd0);
        chk("mid_ready0", {31'b0, req_ready}, 32'd0);
        chk("mid_rdata", resp_rdata, 32'd0);
        chk("mid_err", {31'b0, resp_err}, 32'd0);
        chk("mid_vec", {24'b0, mem_error_vector}, 32'd0);
        chk("mid_seg0", {25'b0, seg0}, 32'h40);
        chk("mid_seg4", {25'b0, seg4}, 32'h40);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post_no_resp", {31'b0, resp_valid}, 32'd0);
        txn("post_rst_lw", 1'b0, 3'b010, 32'h10, 32'd0, 2, 32'hDEAD55EF, 1'b0);
        chk("post_vec", {24'b0, mem_error_vector}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_io_unit.md
Name: mem_io_unit

Overview:
Memory and memory-mapped I/O stage of the multicycle RV32 core. It sits between the datapath's memory-address/memory-data muxes and the IR/regfile input muxes. It accepts one load/store request at a time over a valid/ready handshake and services it from a synchronous word RAM or from I/O registers: switches, buttons, and an eight-digit seven-segment display. It returns read data with sign/zero extension already applied.

Parameters:
RAM_WORDS, 1024, depth of the data/instruction RAM in 32-bit words (power of two)
IO_BASE, 32'hFFFF_0000, base address of the I/O register window

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (size/sign of access)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle pulse: response/completion
resp_rdata  out  32  extended load data (0 for stores and errors)
resp_err  out  1  qualifies resp_valid: access faulted
switch_array  in  16  board switches
button0..button3  in  1 each  raw board push-buttons
seg0..seg7  out  7 each  seven-segment digits, active-low, bit0 = segment a
mem_error_vector  out  8  sticky diagnostic bits

Behaviour:
- Reset: asynchronous on rst=0. Outputs go to the following values:
  - req_ready=0 while rst is asserted, then 1 from the first clock edge after release.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_error_vector=0.
  - Display register=0, so every seg shows "0" (7'b1000000).
  - Button flags cleared and synchronizers cleared.
  - RAM contents are not cleared.
- Handshake: a request is accepted when req_valid && req_ready on a rising edge. All request fields are captured on acceptance. req_ready is low until the response pulse has been issued.
- FSM states: IDLE, RAM_RD, RESP.
  - IDLE with accept:
    - fault (see below) -> RESP with resp_err=1
    - RAM load -> RAM_RD
    - anything else -> RESP
  - RAM_RD -> RESP. The registered RAM word is extracted and extended here.
  - RESP asserts resp_valid for exactly one cycle, then returns to IDLE.
  - Latency, counted from the acceptance edge:
    - RAM load: resp_valid 2 cycles later.
    - Store, I/O read, or fault: resp_valid 1 cycle later.
- RAM: selected when addr < RAM_WORDS*4. Word index is addr[log2(RAM_WORDS)+1:2].
  - Stores use byte enables: SB writes lane addr[1:0]; SH writes lanes {addr[1],0}+{0,1}; SW writes all lanes.
  - RAM is written on the acceptance edge.
- Loads by funct3:
  - 000 LB, 100 LBU: lane addr[1:0], sign-/zero-extended.
  - 001 LH, 101 LHU: half selected by addr[1], sign-/zero-extended.
  - 010 LW: full word.
- I/O window (word access only, funct3=010):
  - IO_BASE+0: switches, read-only, zero-extended; stores ignored.
  - IO_BASE+4: buttons, read-only.
    - Read value = {24'b0, edge_flags[3:0], level[3:0]}.
    - Each button passes through a 2-flop synchronizer. A rising edge of a synchronized button sets its sticky edge flag.
    - A read clears all edge flags. If an edge occurs in the same cycle as the clearing read, the set wins.
  - IO_BASE+8: display register, read/write. Nibble k drives seg{k} through hex decode (0-F).
- Faults: no RAM/register write occurs. Response is resp_err=1, rdata=0. Each fault sets a sticky bit in mem_error_vector:
  - bit0: misaligned (half with addr[0]=1, word with addr[1:0]!=0)
  - bit1: unmapped address
  - bit2: sub-word I/O access
  - bit3: illegal funct3 (load 011/110/111, store >=011)
  - bits 7:4 are reserved, always 0.
  - When several faults apply, all matching bits are set.
- Mid-operation reset: the FSM returns to IDLE immediately and no resp_valid is issued.

Decomposition:
- Package mem_io_pkg:
  - FSM state enum
  - funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW)
  - I/O offset constants (SW_OFS=0, BTN_OFS=4, DISP_OFS=8)
  - error-bit index constants
- Sub-module seven_seg_decoder: 4-bit hex in, 7-bit active-low segments out, instantiated 8 times.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_valid 1 cycle after store accept; load resp_valid exactly 2 cycles after accept with rdata 0xDEADBEEF, req_ready low in between.
- After the above, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; SB 0x55 @0x11 then LW @0x10 -> 0xDEAD55EF.
- switch_array=0xA5C3, LW IO_BASE -> 0x0000A5C3 in 1 cycle; SW 0x01234567 to IO_BASE+8 -> seg0 shows 7, seg7 shows 0, seg4 shows 3 (7'b0110000).
- Pulse button2 high for 5 cycles then low; LW IO_BASE+4 -> 0x00000040; second read -> 0x00000000.
- LW @0x12 -> resp_err=1, rdata=0, mem_error_vector=0x01; LW @0x8000_0000 -> vector 0x03; LB IO_BASE -> vector 0x07; RAM unchanged.
- Assert rst during RAM_RD of a load -> no resp_valid, all outputs reset values, segs all "0"; after release, LW of the same address returns the pre-reset stored data.
